// File: rtl/csr_hpm_counters_pkg.sv
// ============================================================================
// Module : csr_hpm_counters_pkg
// Brief  : CSR address defines and shared constants for the ZCRV counter bank.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ZCRV_CSR_DEFINES
`define ZCRV_CSR_DEFINES
`define ZCRV_CSR_MCOUNTINHIBIT    12'h320
`define ZCRV_CSR_MHPMEVENT3       12'h323
`define ZCRV_CSR_MCYCLE           12'hB00
`define ZCRV_CSR_MCYCLEH          12'hB80
`define ZCRV_CSR_MINSTRET         12'hB02
`define ZCRV_CSR_MINSTRETH        12'hB82
`define ZCRV_CSR_MHPMCOUNTER3     12'hB03
`define ZCRV_CSR_MHPMCOUNTER3H    12'hB83
`define ZCRV_CSR_MHPMEVENT_OF_BIT 31
`endif

package csr_hpm_counters_pkg;

  localparam logic [11:0] c_csr_mcountinhibit  = `ZCRV_CSR_MCOUNTINHIBIT;
  localparam logic [11:0] c_csr_mhpmevent3     = `ZCRV_CSR_MHPMEVENT3;
  localparam logic [11:0] c_csr_mcycle         = `ZCRV_CSR_MCYCLE;
  localparam logic [11:0] c_csr_mcycleh        = `ZCRV_CSR_MCYCLEH;
  localparam logic [11:0] c_csr_minstret       = `ZCRV_CSR_MINSTRET;
  localparam logic [11:0] c_csr_minstreth      = `ZCRV_CSR_MINSTRETH;
  localparam logic [11:0] c_csr_mhpmcounter3   = `ZCRV_CSR_MHPMCOUNTER3;
  localparam logic [11:0] c_csr_mhpmcounter3h  = `ZCRV_CSR_MHPMCOUNTER3H;
  localparam int          c_evt_of_bit         = `ZCRV_CSR_MHPMEVENT_OF_BIT;

  // Counter number (low five address bits) served by slice s: mcycle, minstret, hpm3..
  function automatic logic [4:0] slice_num(input int s);
    return (s == 0) ? 5'd0 : 5'(s + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_hpm_counters_cnt.sv
// ============================================================================
// Module : csr_hpm_cnt
// Brief  : One counter slice with split low/high CSR write and wrap pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_hpm_cnt #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wr_data,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 wrap
);

  localparam logic [CNT_WIDTH-1:0] c_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_cnt;

  // A software write to either half swallows that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) r_cnt[31:0]          <= wr_data;
      if (wr_hi) r_cnt[CNT_WIDTH-1:32] <= wr_data[CNT_WIDTH-33:0];
    end else if (inc) begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign cnt  = r_cnt;
  assign wrap = inc & ~wr_lo & ~wr_hi & (&r_cnt);

endmodule

`default_nettype wire

// File: rtl/csr_hpm_counters.sv
// ============================================================================
// Module : csr_hpm_counters
// Brief  : Machine counter bank (mcycle, minstret, mhpmcounterN/eventN,
//          mcountinhibit). Optional overflow flags via CSR_HPM_OVF_IRQ_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_hpm_counters #(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [11:0]           csr_index,
  input  logic                  csr_en,
  input  logic                  csr_wr_en,
  input  logic                  csr_rd_en,
  input  logic [31:0]           csr_wr_data,
  input  logic                  inst_finish,
  input  logic [NUM_EVENTS-1:0] event_vec,
  output logic                  csr_hit,
  output logic [31:0]           csr_rd_data,
  output logic [31:0]           mcountinhibit_r,
  output logic                  ovf_irq
);

  import csr_hpm_counters_pkg::*;

  localparam int          c_num_cnt  = NUM_HPM + 2;
  localparam logic [31:0] c_inh_mask = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);
  localparam logic [7:0]  c_max_evt  = 8'(NUM_EVENTS);

  logic [4:0]  w_num;
  logic        w_is_inh, w_is_evt, w_is_lo, w_is_hi, w_wr;
  logic [31:0] r_inh, w_rd;

  logic [NUM_HPM-1:0][7:0]            w_evt;
  logic [NUM_HPM-1:0]                 w_of;
  logic [c_num_cnt-1:0]               w_inc, w_wrap;
  logic [c_num_cnt-1:0][CNT_WIDTH-1:0] w_cnt;

  assign w_num    = csr_index[4:0];
  assign w_wr     = csr_en & csr_wr_en;
  assign w_is_inh = (csr_index == c_csr_mcountinhibit);
  assign w_is_evt = (csr_index[11:5] == c_csr_mhpmevent3[11:5]) && (w_num >= c_csr_mhpmevent3[4:0]);
  assign w_is_lo  = (csr_index[11:5] == c_csr_mcycle[11:5]) &&
                    ((w_num == c_csr_mcycle[4:0]) || (w_num == c_csr_minstret[4:0]) ||
                     (w_num >= c_csr_mhpmcounter3[4:0]));
  assign w_is_hi  = (csr_index[11:5] == c_csr_mcycleh[11:5]) &&
                    ((w_num == c_csr_mcycleh[4:0]) || (w_num == c_csr_minstreth[4:0]) ||
                     (w_num >= c_csr_mhpmcounter3h[4:0]));
  assign csr_hit  = w_is_inh | w_is_evt | w_is_lo | w_is_hi;

  // New inhibit value only affects increments from the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_inh <= '0;
    else if (w_wr && w_is_inh) r_inh <= csr_wr_data & c_inh_mask;
  end

  assign mcountinhibit_r = r_inh;
  assign w_inc[0] = ~r_inh[0];
  assign w_inc[1] = inst_finish & ~r_inh[2];

  genvar i;
  generate
    for (i = 0; i < NUM_HPM; i++) begin : g_hpm
      logic       w_sel, w_hit;
      logic [7:0] r_evt;

      assign w_sel = w_wr & w_is_evt & (w_num == 5'(i + 3));

      always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
          if (r_evt == 8'(k + 1) && event_vec[k]) w_hit = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_evt <= '0;
        else if (w_sel) r_evt <= (csr_wr_data[7:0] <= c_max_evt) ? csr_wr_data[7:0] : 8'd0;
      end

      assign w_evt[i]   = r_evt;
      assign w_inc[i+2] = w_hit & ~r_inh[i+3];

`ifdef CSR_HPM_OVF_IRQ_EN
      logic r_of;
      // A wrap in the same cycle as a software clear leaves the flag set.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_of <= 1'b0;
        else if (w_wrap[i+2])   r_of <= 1'b1;
        else if (w_sel)         r_of <= csr_wr_data[c_evt_of_bit];
      end
      assign w_of[i] = r_of;
`else
      assign w_of[i] = 1'b0;
`endif
    end

    for (i = 0; i < c_num_cnt; i++) begin : g_cnt
      localparam logic [4:0] c_num = slice_num(i);

      csr_hpm_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_lo   (w_wr & w_is_lo & (w_num == c_num)),
        .wr_hi   (w_wr & w_is_hi & (w_num == c_num)),
        .wr_data (csr_wr_data),
        .inc     (w_inc[i]),
        .cnt     (w_cnt[i]),
        .wrap    (w_wrap[i])
      );
    end
  endgenerate

`ifdef CSR_HPM_OVF_IRQ_EN
  logic r_ovf_irq;
  logic w_unused_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf_irq <= 1'b0;
    else        r_ovf_irq <= |w_of;
  end

  assign ovf_irq       = r_ovf_irq;
  assign w_unused_wrap = ^w_wrap[1:0];
`else
  logic w_unused_wrap;

  assign ovf_irq       = 1'b0;
  assign w_unused_wrap = ^w_wrap;
`endif

  // Unimplemented counters and events fall through to zero.
  always_comb begin
    w_rd = '0;
    if (w_is_inh) w_rd = r_inh;
    for (int s = 0; s < c_num_cnt; s++) begin
      if (w_is_lo && w_num == slice_num(s)) w_rd = w_cnt[s][31:0];
      if (w_is_hi && w_num == slice_num(s)) w_rd = 32'(w_cnt[s][CNT_WIDTH-1:32]);
    end
    for (int h = 0; h < NUM_HPM; h++) begin
      if (w_is_evt && w_num == 5'(h + 3)) w_rd = {w_of[h], 23'd0, w_evt[h]};
    end
  end

  assign csr_rd_data = (csr_en & csr_rd_en & csr_hit) ? w_rd : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_csr_hpm_counters.sv
// ============================================================================
// Module : tb_csr_hpm_counters
// Brief  : Directed self-checking bench for csr_hpm_counters (64- and 40-bit).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_csr_hpm_counters;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] csr_index = '0;
  logic        csr_en = 1'b0, csr_wr_en = 1'b0, csr_rd_en = 1'b0;
  logic [31:0] csr_wr_data = '0;
  logic        inst_finish = 1'b0;
  logic [7:0]  event_vec = '0;

  logic        csr_hit, ovf_irq, csr_hit40, ovf_irq40;
  logic [31:0] csr_rd_data, mcountinhibit_r, csr_rd_data40, mcountinhibit_r40;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] rd, rd40;
  logic        hit;

  always #5 clk = ~clk;

  csr_hpm_counters #(.NUM_HPM(4), .CNT_WIDTH(64), .NUM_EVENTS(8)) dut (
    .clk(clk), .rst_n(rst_n), .csr_index(csr_index), .csr_en(csr_en),
    .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en), .csr_wr_data(csr_wr_data),
    .inst_finish(inst_finish), .event_vec(event_vec), .csr_hit(csr_hit),
    .csr_rd_data(csr_rd_data), .mcountinhibit_r(mcountinhibit_r), .ovf_irq(ovf_irq)
  );

  csr_hpm_counters #(.NUM_HPM(4), .CNT_WIDTH(40), .NUM_EVENTS(8)) dut40 (
    .clk(clk), .rst_n(rst_n), .csr_index(csr_index), .csr_en(csr_en),
    .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en), .csr_wr_data(csr_wr_data),
    .inst_finish(inst_finish), .event_vec(event_vec), .csr_hit(csr_hit40),
    .csr_rd_data(csr_rd_data40), .mcountinhibit_r(mcountinhibit_r40), .ovf_irq(ovf_irq40)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_index = a; csr_wr_data = d; csr_en = 1'b1; csr_wr_en = 1'b1;
    @(posedge clk);
    #1;
    csr_en = 1'b0; csr_wr_en = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a);
    csr_index = a; csr_en = 1'b1; csr_rd_en = 1'b1;
    #1;
    rd = csr_rd_data; rd40 = csr_rd_data40; hit = csr_hit;
    csr_en = 1'b0; csr_rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ovf_irq", {31'd0, ovf_irq}, 32'd0);
    check_val("rst_inhibit_port", mcountinhibit_r, 32'd0);
    check_val("rst_inhibit_port_w40", mcountinhibit_r40, 32'd0);
    rst_n = 1'b1;

    // Idle after reset release
    tick(10);
    csr_read(12'hB00); check_val("t1_mcycle", rd, 32'd10);
    csr_read(12'hB80); check_val("t1_mcycleh", rd, 32'd0);
    csr_read(12'hB02); check_val("t1_minstret", rd, 32'd0);
    csr_read(12'hB03); check_val("t1_hpm3", rd, 32'd0);
    csr_read(12'h320); check_val("t1_inhibit", rd, 32'd0);
    check_val("t1_inhibit_hit", {31'd0, hit}, 32'd1);

    // Carry into the high half, high-half width, full wrap
    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_write(12'hB80, 32'h0);
    csr_read(12'hB00); check_val("t2_hi_write_holds_lo", rd, 32'hFFFF_FFFF);
    tick(1);
    csr_read(12'hB80); check_val("t2_mcycleh_carry", rd, 32'd1);
    check_val("t2_mcycleh_carry_w40", rd40, 32'd1);
    csr_read(12'hB00); check_val("t2_mcycle_lo_zero", rd, 32'd0);
    csr_write(12'hB80, 32'hFFFF_FFFF);
    csr_read(12'hB80); check_val("t2_mcycleh_full", rd, 32'hFFFF_FFFF);
    check_val("t2_mcycleh_w40_trunc", rd40, 32'h0000_00FF);
    csr_write(12'hB00, 32'hFFFF_FFFF);
    tick(1);
    csr_read(12'hB00); check_val("t2_wrap_lo", rd, 32'd0);
    csr_read(12'hB80); check_val("t2_wrap_hi", rd, 32'd0);
    check_val("t2_wrap_hi_w40", rd40, 32'd0);

    // Event selection and WARL event register
    csr_write(12'h323, 32'h7FFF_FF02);
    csr_read(12'h323); check_val("t3_evt3_warl", rd, 32'd2);
    event_vec = 8'h02; tick(5);
    event_vec = 8'h01; tick(3);
    event_vec = 8'h00;
    csr_read(12'hB03); check_val("t3_hpm3", rd, 32'd5);
    csr_read(12'hB83); check_val("t3_hpm3h", rd, 32'd0);
    csr_write(12'h324, 32'd9);
    csr_read(12'h324); check_val("t3_evt4_illegal", rd, 32'd0);
    csr_write(12'h324, 32'd8);
    csr_read(12'h324); check_val("t3_evt4_max", rd, 32'd8);

    // Inhibit takes effect the cycle after the write
    csr_write(12'hB00, 32'h100);
    inst_finish = 1'b1;
    csr_write(12'h320, 32'h5);
    tick(3);
    inst_finish = 1'b0;
    csr_read(12'hB00); check_val("t4_mcycle_frozen", rd, 32'h101);
    csr_read(12'hB02); check_val("t4_minstret_once", rd, 32'd1);
    csr_read(12'h320); check_val("t4_inhibit_rd", rd, 32'h5);
    check_val("t4_inhibit_port", mcountinhibit_r, 32'h5);
    csr_write(12'h320, 32'hFFFF_FFFF);
    csr_read(12'h320); check_val("t4_inhibit_mask", rd, 32'h7D);
    event_vec = 8'h02; tick(2);
    event_vec = 8'h00;
    csr_read(12'hB03); check_val("t4_hpm3_inhibited", rd, 32'd5);
    csr_write(12'h320, 32'h0);

    // Write beats increment; unimplemented and foreign addresses
    inst_finish = 1'b1;
    csr_write(12'hB02, 32'd7);
    inst_finish = 1'b0;
    csr_read(12'hB02); check_val("t5_minstret_wr_wins", rd, 32'd7);
    inst_finish = 1'b1; tick(1); inst_finish = 1'b0;
    csr_read(12'hB02); check_val("t5_minstret_inc", rd, 32'd8);
    csr_read(12'hB1F); check_val("t5_hpm31_zero", rd, 32'd0);
    check_val("t5_hpm31_hit", {31'd0, hit}, 32'd1);
    csr_read(12'h33F); check_val("t5_evt31_zero", rd, 32'd0);
    check_val("t5_evt31_hit", {31'd0, hit}, 32'd1);
    csr_read(12'h321); check_val("t5_321_no_hit", {31'd0, hit}, 32'd0);
    csr_read(12'hB01); check_val("t5_b01_no_hit", {31'd0, hit}, 32'd0);
    csr_index = 12'hB02; csr_en = 1'b1;
    #1;
    check_val("t5_no_rd_en_data", csr_rd_data, 32'd0);
    check_val("t5_no_rd_en_hit", {31'd0, csr_hit}, 32'd1);
    csr_en = 1'b0;

    // hpm3 wrap and overflow flag
    csr_write(12'h323, 32'd1);
    csr_write(12'hB83, 32'hFFFF_FFFF);
    csr_write(12'hB03, 32'hFFFF_FFFF);
    event_vec = 8'h01; tick(1); event_vec = 8'h00;
    csr_read(12'hB03); check_val("t6_hpm3_wrap_lo", rd, 32'd0);
    csr_read(12'hB83); check_val("t6_hpm3_wrap_hi", rd, 32'd0);
    check_val("t6_hpm3_wrap_hi_w40", rd40, 32'd0);
`ifdef CSR_HPM_OVF_IRQ_EN
    csr_read(12'h323); check_val("t6_of_set", rd, 32'h8000_0001);
    check_val("t6_irq_lag", {31'd0, ovf_irq}, 32'd0);
    tick(1);
    check_val("t6_irq_set", {31'd0, ovf_irq}, 32'd1);
    csr_write(12'h323, 32'd1);
    csr_read(12'h323); check_val("t6_of_cleared", rd, 32'd1);
    check_val("t6_irq_still_reg", {31'd0, ovf_irq}, 32'd1);
    tick(1);
    check_val("t6_irq_clear", {31'd0, ovf_irq}, 32'd0);
    csr_write(12'hB83, 32'hFFFF_FFFF);
    csr_write(12'hB03, 32'hFFFF_FFFF);
    event_vec = 8'h01;
    csr_write(12'h323, 32'd1);
    event_vec = 8'h00;
    csr_read(12'h323); check_val("t6_set_beats_clear", rd, 32'h8000_0001);
`else
    csr_read(12'h323); check_val("t6_of_absent", rd, 32'd1);
    csr_write(12'h323, 32'h8000_0001);
    csr_read(12'h323); check_val("t6_of_wr_ignored", rd, 32'd1);
    tick(1);
    check_val("t6_irq_tied", {31'd0, ovf_irq}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
